// File: rtl/viterbi_ber_checker_if.sv
// viterbi_ber_checker_if: reference/decoded bit streams in, lock and BER statistics out.
interface viterbi_ber_checker_if #(parameter int LAT_W = 6, parameter int CNT_W = 32);
  logic             ref_valid;
  logic             ref_bit;
  logic             dec_valid;
  logic             dec_bit;
  logic             clear;
  logic             locked;
  logic [LAT_W-1:0] latency;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;
  logic             lost_lock;
  logic             sat;
  modport master (output ref_valid, ref_bit, dec_valid, dec_bit, clear,
                  input locked, latency, bit_count, err_count, lost_lock, sat);
  modport slave  (input ref_valid, ref_bit, dec_valid, dec_bit, clear,
                  output locked, latency, bit_count, err_count, lost_lock, sat);
endinterface

// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker: finds decoder latency against transmitted history, then counts residual bit errors.
module viterbi_ber_checker #(
  parameter int MAX_LAT  = 64,
  parameter int WIN      = 32,
  parameter int LOCK_THR = 2,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32
) (
  input logic clk,
  input logic rst,
  viterbi_ber_checker_if.slave bus
);
  localparam int LW = $clog2(MAX_LAT);
  localparam int FW = LW + 1;
  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(WIN) + 1;
  typedef enum logic {SEARCH, LOCK} state_t;
  state_t             state;
  logic [MAX_LAT-1:0] hist;
  logic [FW-1:0]      fill;
  logic [LW-1:0]      cand;
  logic [WW-1:0]      win_bits;
  logic [EW-1:0]      win_errs;
  logic               hit, mis, close;
  logic [EW-1:0]      errs;
  logic [CNT_W-1:0]   bit_nxt, err_nxt;
  // hist holds only bits from earlier cycles, so the compare sees pre-shift history
  always_comb begin
    hit     = bus.dec_valid && (fill > {1'b0, cand});
    mis     = bus.dec_bit ^ hist[cand];
    errs    = win_errs + EW'(mis);
    close   = hit && (win_bits == WW'(WIN - 1));
    bit_nxt = bus.bit_count + CNT_W'(~&bus.bit_count);
    err_nxt = bus.err_count + CNT_W'(mis & ~&bus.err_count);
  end
  assign bus.locked  = (state == LOCK);
  assign bus.latency = cand;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= SEARCH;
      hist          <= '0;
      fill          <= '0;
      cand          <= '0;
      win_bits      <= '0;
      win_errs      <= '0;
      bus.bit_count <= '0;
      bus.err_count <= '0;
      bus.lost_lock <= 1'b0;
      bus.sat       <= 1'b0;
    end else if (bus.clear) begin
      state         <= SEARCH;
      cand          <= '0;
      win_bits      <= '0;
      win_errs      <= '0;
      bus.bit_count <= '0;
      bus.err_count <= '0;
      bus.lost_lock <= 1'b0;
      bus.sat       <= 1'b0;
    end else begin
      bus.lost_lock <= 1'b0;
      if (bus.ref_valid) begin
        hist <= {hist[MAX_LAT-2:0], bus.ref_bit};
        fill <= (fill == FW'(MAX_LAT)) ? fill : fill + 1'b1;
      end
      if (hit) begin
        win_bits <= close ? '0 : win_bits + 1'b1;
        win_errs <= close ? '0 : errs;
        if (state == LOCK) begin
          bus.bit_count <= bit_nxt;
          bus.err_count <= err_nxt;
          bus.sat       <= bus.sat | (&bit_nxt) | (&err_nxt);
        end
        if (close && state == SEARCH) begin
          if (errs <= EW'(LOCK_THR)) state <= LOCK;
          else cand <= (cand == LW'(MAX_LAT - 1)) ? '0 : cand + 1'b1;
        end
        if (close && state == LOCK && errs > EW'(LOSS_THR)) begin
          state         <= SEARCH;
          cand          <= '0;
          bus.lost_lock <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb_viterbi_ber_checker: directed phases against a queue-based reference model; 32-bit and 8-bit counter instances.
module tb_viterbi_ber_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ref_valid = 1'b0, ref_bit = 1'b0, dec_valid = 1'b0, dec_bit = 1'b0, clear = 1'b0;
  int   total = 0, passed = 0, lost_seen = 0;
  bit   chk_en = 1'b0;
  bit   ref_q[$];
  bit   sent_q[$];
  logic [15:0] lfsr = 16'hACE1;
  bit      m_locked = 0, m_lost = 0;
  int      m_cand = 0, m_wb = 0, m_we = 0;
  longint  m_bits = 0, m_errs = 0;
  viterbi_ber_checker_if #(.LAT_W(6), .CNT_W(32)) b32();
  viterbi_ber_checker_if #(.LAT_W(6), .CNT_W(8))  b8();
  assign b32.ref_valid = ref_valid;
  assign b32.ref_bit   = ref_bit;
  assign b32.dec_valid = dec_valid;
  assign b32.dec_bit   = dec_bit;
  assign b32.clear     = clear;
  assign b8.ref_valid  = ref_valid;
  assign b8.ref_bit    = ref_bit;
  assign b8.dec_valid  = dec_valid;
  assign b8.dec_bit    = dec_bit;
  assign b8.clear      = clear;
  viterbi_ber_checker #(.CNT_W(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  viterbi_ber_checker #(.CNT_W(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference model: history is a plain list of accepted ref bits; latency indexes back from the newest.
  task automatic model_step(input bit rv, input bit rb, input bit dv, input bit db, input bit clr);
    bit m;
    if (clr) begin
      m_bits = 0; m_errs = 0; m_wb = 0; m_we = 0; m_locked = 0; m_cand = 0; m_lost = 0;
      return;
    end
    m_lost = 0;
    if (dv && ref_q.size() > m_cand) begin
      m = db ^ ref_q[ref_q.size() - 1 - m_cand];
      if (m_locked) begin m_bits++; m_errs += m; end
      m_wb++; m_we += m;
      if (m_wb == 32) begin
        if (!m_locked) begin
          if (m_we <= 2) m_locked = 1;
          else m_cand = (m_cand + 1) % 64;
        end else if (m_we > 8) begin
          m_locked = 0; m_cand = 0; m_lost = 1;
        end
        m_wb = 0; m_we = 0;
      end
    end
    if (rv) begin
      ref_q.push_back(rb);
      if (ref_q.size() > 64) void'(ref_q.pop_front());
    end
  endtask

  // Decoded stream: the ref bit five positions behind the newest held one, optionally inverted.
  task automatic drive(input bit rv, input bit dv, input bit flip, input bit clr);
    ref_valid = rv;
    ref_bit   = lfsr[0];
    dec_valid = dv;
    dec_bit   = (sent_q.size() > 5 ? sent_q[sent_q.size() - 6] : 1'($urandom_range(0, 1))) ^ flip;
    clear     = clr;
    @(posedge clk);
    model_step(rv, ref_bit, dv, dec_bit, clr);
    if (rv && !clr) begin
      sent_q.push_back(ref_bit);
      if (sent_q.size() > 64) void'(sent_q.pop_front());
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && chk_en) begin
      if (b32.lost_lock) lost_seen++;
      chk("locked", b32.locked, m_locked);
      chk("latency", b32.latency, m_cand);
      chk("bit_count", b32.bit_count, m_bits);
      chk("err_count", b32.err_count, m_errs);
      chk("lost_lock", b32.lost_lock, m_lost);
      chk("sat", b32.sat, 0);
      chk("bit_count8", b8.bit_count, m_bits > 255 ? 255 : m_bits);
      chk("err_count8", b8.err_count, m_errs > 255 ? 255 : m_errs);
      chk("sat8", b8.sat, (m_bits >= 255 || m_errs >= 255) ? 1 : 0);
      chk("locked8", b8.locked, m_locked);
    end
  end

  initial begin
    longint e0, b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", b32.locked, 0);
    chk("rst_latency", b32.latency, 0);
    chk("rst_bits", b32.bit_count, 0);
    chk("rst_errs", b32.err_count, 0);
    chk("rst_lost", b32.lost_lock, 0);
    chk("rst_sat", b32.sat, 0);
    rst = 1'b1;
    chk_en = 1'b1;
    // clean acquisition: one dropped bit, then five failing windows and a locking one
    repeat (193) drive(1, 1, 0, 0);
    chk("acq_locked", b32.locked, 1);
    chk("acq_latency", b32.latency, 5);
    chk("acq_errs", b32.err_count, 0);
    e0 = b32.err_count;
    for (int i = 0; i < 128; i++) drive(1, 1, (i % 32) == 0, 0);
    chk("sparse_err_delta", b32.err_count - e0, 4);
    chk("sparse_locked", b32.locked, 1);
    for (int i = 0; i < 40 && m_wb != 0; i++) drive(1, 1, 0, 0);
    b0 = b32.bit_count;
    lost_seen = 0;
    repeat (10) drive(1, 1, 1, 0);
    repeat (256) drive(1, 1, 0, 0);
    chk("burst_lost_pulses", lost_seen, 1);
    chk("relock", b32.locked, 1);
    chk("relock_latency", b32.latency, 5);
    chk("bits_kept", b32.bit_count >= b0, 1);
    drive(1, 1, 0, 1);
    chk("clr_bits", b32.bit_count, 0);
    chk("clr_errs", b32.err_count, 0);
    chk("clr_locked", b32.locked, 0);
    chk("clr_latency", b32.latency, 0);
    repeat (800) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    chk("gappy_locked", b32.locked, 1);
    chk("gappy_latency", b32.latency, 5);
    repeat (300) drive(1, 1, 0, 0);
    chk("sat8_bits", b8.bit_count, 255);
    chk("sat8_flag", b8.sat, 1);
    chk("sat32_flag", b32.sat, 0);
    drive(1, 1, 0, 1);
    chk("sat8_cleared", b8.sat, 0);
    chk("bits8_cleared", b8.bit_count, 0);
    repeat (10) drive(1, 1, 0, 0);
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_locked", b32.locked, 0);
    chk("arst_latency", b32.latency, 0);
    chk("arst_bits", b32.bit_count, 0);
    chk("arst_errs", b32.err_count, 0);
    chk("arst_lost", b32.lost_lock, 0);
    chk("arst_sat8", b8.sat, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
